// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters take turns on one UART transmitter.
// Latency: req_ready is combinational in IDLE; send_request rises one cycle after the grant edge.
// Backpressure: no grant while busy, while tx_busy is high, or before the current frame returns to IDLE.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int LAUNCH_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_BITS-1:0]          tx_data,
  output logic                          send_request,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   last_grant;
  logic [CW-1:0]   to_cnt;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   rr_idx;
  logic            found;
  logic            grant;
  logic            to_hit;

  // Round-robin search starting one past the last granted requester, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  // Grant only from IDLE with the transmitter free; ready is held low throughout reset.
  always_comb begin
    grant     = (state == S_IDLE) && !tx_busy && found;
    req_ready = '0;
    if (grant && resetn) begin
      req_ready = NUM_REQ'(1) << winner;
    end
  end

  // Launch window expires on the last permitted LAUNCH cycle with no response from the UART.
  always_comb begin
    to_hit = (state == S_LAUNCH) && !tx_done && !tx_busy &&
             (to_cnt == CW'(LAUNCH_TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; tx_done in LAUNCH wins over tx_busy so a short frame is not missed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (tx_done)      state_nxt = S_IDLE;
        else if (tx_busy) state_nxt = S_WAIT_DONE;
        else if (to_hit)  state_nxt = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (tx_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    send_request = (state == S_LAUNCH);
    arb_busy     = (state != S_IDLE);
  end

  // Grant capture, launch timer and sticky timeout flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant) begin
        tx_data    <= req_data[winner*DATA_BITS +: DATA_BITS];
        grant_id   <= winner;
        last_grant <= winner;
        to_cnt     <= '0;
      end else if (state == S_LAUNCH) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, width of one transmitted character.
REQ-003 The block SHALL have parameter LAUNCH_TIMEOUT, default 16, maximum cycles to wait for tx_busy after launch.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  bit i high: requester i holds a character to send.
REQ-007 req_data  input  NUM_REQ*DATA_BITS  requester i character at bits [i*DATA_BITS +: DATA_BITS].
REQ-008 req_ready  output  NUM_REQ  one-hot; transfer from requester i occurs on an edge where req_valid[i] and req_ready[i] are both high.
REQ-009 tx_data  output  DATA_BITS  character presented to the UART transmitter.
REQ-010 send_request  output  1  launch strobe to the UART transmitter.
REQ-011 tx_busy  input  1  UART transmitter is shifting a frame.
REQ-012 tx_done  input  1  one-cycle pulse at end of a frame.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the most recently granted requester.
REQ-014 arb_busy  output  1  high whenever the state is not IDLE.
REQ-015 timeout_err  output  1  sticky flag; tx_busy failed to rise within LAUNCH_TIMEOUT.

Function
REQ-016 The block SHALL implement states IDLE, LAUNCH and WAIT_DONE.
REQ-017 In IDLE, with tx_busy low and any req_valid high, the block SHALL drive req_ready combinationally one-hot on the round-robin winner; otherwise req_ready SHALL be all zero.
REQ-018 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ and wrap; last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
REQ-019 On the grant edge the block SHALL latch the winner's req_data into tx_data, load grant_id and last_grant with the winner index, clear the timeout counter, and enter LAUNCH.
REQ-020 tx_data SHALL hold its value from the grant edge until the next grant.
REQ-021 send_request SHALL be high exactly while the state is LAUNCH, so it rises one cycle after the grant edge.
REQ-022 In LAUNCH, sampling tx_busy high SHALL move the state to WAIT_DONE.
REQ-023 In LAUNCH, sampling tx_done high (including simultaneously with tx_busy) SHALL move the state directly to IDLE.
REQ-024 In LAUNCH, the timeout counter SHALL increment each cycle.
REQ-025 If LAUNCH_TIMEOUT cycles elapse in LAUNCH without tx_busy or tx_done, the block SHALL set timeout_err, return to IDLE and drop the character without retry.
REQ-026 In WAIT_DONE, the block SHALL return to IDLE on the edge where tx_done is sampled high, independent of tx_busy.
REQ-027 From the edge that moves the state to IDLE, the block SHALL be able to grant on the next cycle, giving a two-cycle minimum gap between successive send_request assertions.
REQ-028 The block SHALL never issue a second grant before the current transfer reaches IDLE.
REQ-029 The block SHALL ignore req_valid changes outside IDLE.
REQ-030 The block SHALL ignore tx_done while in IDLE.
REQ-031 timeout_err SHALL clear only by reset.

Reset
REQ-032 resetn low SHALL immediately force: state IDLE, send_request 0, tx_data 0, grant_id 0, last_grant NUM_REQ-1, timeout counter 0, timeout_err 0, arb_busy 0.
REQ-033 resetn low SHALL force req_ready to 0 while resetn is low.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer without any completion pulse.
REQ-035 After resetn deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-036 req_valid=4'b0100, req_data[23:16]=8'hD5, tx_busy low -> req_ready=4'b0100 for one cycle; then tx_data=8'hD5, grant_id=2, send_request high until tx_busy sampled; return to IDLE after tx_done.
REQ-037 req_valid=4'b1111 held, UART model completing each frame -> grant_id sequence 0,1,2,3,0.
REQ-038 last grant 1, req_valid=4'b1011 -> next grant 3, then 0, then 1.
REQ-039 tx_busy held low, tx_done never pulses -> send_request high for exactly 16 cycles, then low; timeout_err=1; next grant proceeds normally with timeout_err still 1.
REQ-040 resetn pulsed low during WAIT_DONE -> send_request, arb_busy and timeout_err at 0 before the next edge; with req_valid=4'b1111, next grant goes to requester 0.
REQ-041 tx_busy high in IDLE (external user) with req_valid=4'b0001 -> req_ready stays 0 until tx_busy falls; grant follows in that cycle.
